// File: rtl/reg_wb_pkg.sv
// Shared types and constants for the register-file writeback controller.
package reg_wb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } wb_state_t;

  localparam logic       SRC_ALU   = 1'b0;
  localparam logic       SRC_MEM   = 1'b1;
  localparam logic [2:0] R7_IDX    = 3'b111;
  localparam logic [2:0] NZP_RESET = 3'b010;

endpackage

// File: rtl/reg_writeback_ctrl_nzp_gen.sv
// LC-3 condition-code decode: exactly one of {N,Z,P} is set for any value.
module nzp_gen #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] value_i,
  output logic [2:0]       nzp_o
);

  // Sign bit takes priority, then zero test, otherwise positive.
  always_comb begin
    nzp_o = 3'b001;
    if (value_i[WIDTH-1])
      nzp_o = 3'b100;
    else if (value_i == '0)
      nzp_o = 3'b010;
  end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Writeback sequencer for the 8 x 16 register file: accepts one request per
// instruction, waits for load data when needed, then issues a single-cycle
// register write and an optional NZP update. All outputs are registered, so
// the write strobe and its data are loaded on the edge that enters WRITE.
module reg_writeback_ctrl
  import reg_wb_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [15:0]      IR,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_src,
  input  logic             req_drmux,
  input  logic             req_set_cc,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] mem_data,
  input  logic             mem_ready,
  output logic [WIDTH-1:0] wb_data,
  output logic [2:0]       wb_dr,
  output logic             LD_REG,
  output logic             LD_CC,
  output logic [2:0]       NZP,
  output logic             timeout_err
);

  // Last WAIT_MEM cycle before the load is abandoned.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  wb_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       dr_q, dr_d;
  logic             set_cc_q, set_cc_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;
  logic [2:0]       wb_dr_q, wb_dr_d;
  logic             ld_reg_q, ld_reg_d;
  logic             ld_cc_q, ld_cc_d;
  logic [2:0]       nzp_q, nzp_d;
  logic             to_q, to_d;

  logic [WIDTH-1:0] wr_val;
  logic [2:0]       wr_nzp;
  logic [2:0]       accept_dr;

  // Only the DR field of the instruction matters here.
  logic unused_ir;
  assign unused_ir = ^{IR[15:12], IR[8:0]};

  assign accept_dr = req_drmux ? IR[11:9] : R7_IDX;

  // Value about to be written: load data while waiting, ALU result otherwise.
  always_comb begin
    wr_val = alu_result;
    if (state_q == WAIT_MEM)
      wr_val = mem_data;
  end

  nzp_gen #(
    .WIDTH (WIDTH)
  ) u_nzp_gen (
    .value_i (wr_val),
    .nzp_o   (wr_nzp)
  );

  // Next-state and registered-output decode for the three-state sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dr_d      = dr_q;
    set_cc_d  = set_cc_q;
    wb_data_d = wb_data_q;
    wb_dr_d   = wb_dr_q;
    nzp_d     = nzp_q;
    ld_reg_d  = 1'b0;
    ld_cc_d   = 1'b0;
    to_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          dr_d     = accept_dr;
          set_cc_d = req_set_cc;
          if (req_src == SRC_ALU) begin
            wb_data_d = wr_val;
            wb_dr_d   = accept_dr;
            ld_reg_d  = 1'b1;
            ld_cc_d   = req_set_cc;
            state_d   = WRITE;
          end else begin
            cnt_d   = '0;
            state_d = WAIT_MEM;
          end
        end
      end
      WAIT_MEM: begin
        // Arriving data beats the timeout on the same cycle.
        if (mem_ready) begin
          wb_data_d = wr_val;
          wb_dr_d   = dr_q;
          ld_reg_d  = 1'b1;
          ld_cc_d   = set_cc_q;
          state_d   = WRITE;
        end else if (cnt_q == CNT_LAST) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (ld_cc_d)
      nzp_d = wr_nzp;
  end

  // State and output registers; reset drops any pending write.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dr_q      <= '0;
      set_cc_q  <= 1'b0;
      wb_data_q <= '0;
      wb_dr_q   <= '0;
      ld_reg_q  <= 1'b0;
      ld_cc_q   <= 1'b0;
      nzp_q     <= NZP_RESET;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dr_q      <= dr_d;
      set_cc_q  <= set_cc_d;
      wb_data_q <= wb_data_d;
      wb_dr_q   <= wb_dr_d;
      ld_reg_q  <= ld_reg_d;
      ld_cc_q   <= ld_cc_d;
      nzp_q     <= nzp_d;
      to_q      <= to_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign wb_data     = wb_data_q;
  assign wb_dr       = wb_dr_q;
  assign LD_REG      = ld_reg_q;
  assign LD_CC       = ld_cc_q;
  assign NZP         = nzp_q;
  assign timeout_err = to_q;

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Scoreboard bench for reg_writeback_ctrl: stimulus pushes expected outputs,
// a negedge monitor pops and compares whenever LD_REG or timeout_err fires.
module tb_reg_writeback_ctrl;

  logic        Clk, Reset;
  logic [15:0] IR;
  logic        req_valid, req_ready, req_src, req_drmux, req_set_cc;
  logic [15:0] alu_result, mem_data;
  logic        mem_ready;
  logic [15:0] wb_data;
  logic [2:0]  wb_dr;
  logic        LD_REG, LD_CC;
  logic [2:0]  NZP;
  logic        timeout_err;

  reg_writeback_ctrl #(.WIDTH(16), .MEM_TIMEOUT(15), .CNT_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .IR(IR),
    .req_valid(req_valid), .req_ready(req_ready), .req_src(req_src),
    .req_drmux(req_drmux), .req_set_cc(req_set_cc),
    .alu_result(alu_result), .mem_data(mem_data), .mem_ready(mem_ready),
    .wb_data(wb_data), .wb_dr(wb_dr), .LD_REG(LD_REG), .LD_CC(LD_CC),
    .NZP(NZP), .timeout_err(timeout_err)
  );

  typedef struct {
    int          cyc;
    bit          is_to;
    logic [2:0]  dr;
    logic [15:0] data;
    bit          cc;
    logic [2:0]  nzp;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_wr(input int c, input logic [2:0] dr, input logic [15:0] d,
                         input bit cc, input logic [2:0] nzp);
    exp_t e;
    e.cyc = c; e.is_to = 1'b0; e.dr = dr; e.data = d; e.cc = cc; e.nzp = nzp;
    sb.push_back(e);
  endtask

  task automatic push_to(input int c);
    exp_t e;
    e.cyc = c; e.is_to = 1'b1; e.dr = '0; e.data = '0; e.cc = 1'b0; e.nzp = '0;
    sb.push_back(e);
  endtask

  // Hold a request until accepted; acc is the cycle in which valid && ready.
  task automatic send(input bit src, input bit drmux, input bit setcc,
                      input logic [15:0] ir, input logic [15:0] alu, output int acc);
    req_src = src; req_drmux = drmux; req_set_cc = setcc;
    IR = ir; alu_result = alu; req_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 40; i++) begin
      if (req_ready) begin
        acc = cyc;
        tick();
        break;
      end
      tick();
    end
    req_valid = 1'b0;
    if (acc < 0) chk("accept_bound", 0, 1);
  endtask

  // Monitor: compare every write strobe or timeout pulse with the scoreboard.
  always @(negedge Clk) begin
    exp_t e;
    if (!Reset) begin
      if (LD_CC) chk("ld_cc_with_ld_reg", LD_REG, 1);
      if (LD_REG || timeout_err) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: ld_reg=%0b timeout_err=%0b at cycle %0d, required none",
                   LD_REG, timeout_err, cyc);
        end else begin
          e = sb.pop_front();
          chk("out_cycle", cyc, e.cyc);
          chk("timeout_err", timeout_err, e.is_to);
          chk("ld_reg", LD_REG, !e.is_to);
          if (!e.is_to) begin
            chk("wb_dr", wb_dr, e.dr);
            chk("wb_data", wb_data, e.data);
            chk("ld_cc", LD_CC, e.cc);
            chk("nzp", NZP, e.nzp);
          end
        end
      end
    end
  end

  initial begin
    int a, b;
    Reset = 1'b1; IR = '0; req_valid = 1'b0; req_src = 1'b0; req_drmux = 1'b0;
    req_set_cc = 1'b0; alu_result = '0; mem_data = '0; mem_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_wb_data", wb_data, 16'h0000);
    chk("rst_wb_dr", wb_dr, 3'd0);
    chk("rst_ld_reg", LD_REG, 0);
    chk("rst_ld_cc", LD_CC, 0);
    chk("rst_nzp", NZP, 3'b010);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_ready", req_ready, 1);
    Reset = 1'b0;
    tick();

    // ALU write to R5, negative -> N
    send(1'b0, 1'b1, 1'b1, 16'h1A42, 16'h8001, a);
    push_wr(a + 1, 3'd5, 16'h8001, 1'b1, 3'b100);
    chk("ready_in_write", req_ready, 0);

    // Back-to-back link write to R7, no CC update
    send(1'b0, 1'b0, 1'b0, 16'h1A42, 16'h3005, b);
    push_wr(b + 1, 3'd7, 16'h3005, 1'b0, 3'b100);
    chk("b2b_spacing", b - a, 2);
    tick();
    tick();
    chk("hold_wb_data", wb_data, 16'h3005);
    chk("hold_wb_dr", wb_dr, 3'd7);
    chk("idle_ld_reg", LD_REG, 0);
    chk("hold_nzp", NZP, 3'b100);

    // Positive ALU value to R3 -> P
    send(1'b0, 1'b1, 1'b1, 16'h0600, 16'h0042, a);
    push_wr(a + 1, 3'd3, 16'h0042, 1'b1, 3'b001);

    // mem_ready outside WAIT_MEM must be ignored
    mem_ready = 1'b1; mem_data = 16'hFFFF;
    repeat (3) tick();
    mem_ready = 1'b0;

    // Load to R2 with 3 wait cycles, zero data -> Z
    send(1'b1, 1'b1, 1'b1, 16'h2400, 16'h0000, a);
    for (int i = 0; i < 3; i++) begin
      chk("ready_wait_mem", req_ready, 0);
      tick();
    end
    mem_ready = 1'b1; mem_data = 16'h0000;
    push_wr(cyc + 1, 3'd2, 16'h0000, 1'b1, 3'b010);
    chk("ready_mem_cycle", req_ready, 0);
    tick();
    mem_ready = 1'b0;
    chk("ready_load_write", req_ready, 0);
    tick();

    // Timeout: no data for 15 WAIT_MEM cycles
    send(1'b1, 1'b1, 1'b1, 16'h0E00, 16'h0000, a);
    push_to(a + 16);
    repeat (14) tick();
    chk("ready_before_timeout", req_ready, 0);
    tick();
    chk("ready_after_timeout", req_ready, 1);
    chk("nzp_after_timeout", NZP, 3'b010);
    tick();

    // Busy: ALU request held during a load, accepted right after WRITE
    send(1'b1, 1'b1, 1'b0, 16'h0200, 16'h0000, a);
    req_src = 1'b0; req_drmux = 1'b1; req_set_cc = 1'b1;
    IR = 16'h0C00; alu_result = 16'hFFFE; req_valid = 1'b1;
    chk("busy_ready_1", req_ready, 0);
    tick();
    chk("busy_ready_2", req_ready, 0);
    tick();
    mem_ready = 1'b1; mem_data = 16'h1234;
    push_wr(cyc + 1, 3'd1, 16'h1234, 1'b0, 3'b010);
    chk("busy_ready_3", req_ready, 0);
    tick();
    mem_ready = 1'b0;
    chk("busy_ready_write", req_ready, 0);
    tick();
    chk("busy_ready_idle", req_ready, 1);
    push_wr(cyc + 1, 3'd6, 16'hFFFE, 1'b1, 3'b100);
    tick();
    req_valid = 1'b0;
    tick();

    // Tie: mem_ready on the timeout cycle -> write wins
    send(1'b1, 1'b1, 1'b1, 16'h0800, 16'h0000, a);
    repeat (14) tick();
    mem_ready = 1'b1; mem_data = 16'h7FFF;
    push_wr(cyc + 1, 3'd4, 16'h7FFF, 1'b1, 3'b001);
    tick();
    mem_ready = 1'b0;
    repeat (2) tick();
    chk("nzp_before_reset", NZP, 3'b001);

    // Reset in the middle of a load drops it
    send(1'b1, 1'b1, 1'b1, 16'h0A00, 16'h0000, a);
    tick();
    Reset = 1'b1; mem_ready = 1'b1; mem_data = 16'h8000;
    tick();
    Reset = 1'b0;
    chk("midrst_ld_reg", LD_REG, 0);
    chk("midrst_nzp", NZP, 3'b010);
    chk("midrst_ready", req_ready, 1);
    chk("midrst_wb_data", wb_data, 16'h0000);
    repeat (3) tick();
    mem_ready = 1'b0;
    repeat (3) tick();

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
